multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main sequencer for the multicycle RISC-V core. A Moore FSM with a combinational ALU decoder and immediate-format decoder. It drives every datapath select and write-enable inside the core for each instruction phase: fetch, decode, execute, memory and writeback. It consumes the latched instruction fields plus the ALU `Zero`/`Sign` flags and sits beside the datapath inside the CPU wrapper.

## Interface
- No parameters.
- `clk`  in  1  core clock
- `reset`  in  1  asynchronous, active-high; forces state FETCH
- `op`  in  7  instr[6:0] from instruction register
- `funct3`  in  3  instr[14:12]
- `funct7b5`  in  1  instr[30]
- `Zero`  in  1  ALU result == 0
- `Sign`  in  1  ALU result[31]
- `PCWrite`  out  1  PC register enable
- `AdrSrc`  out  1  memory address: 0=PC, 1=Result
- `MemWrite`  out  1  memory write strobe
- `IRWrite`  out  1  instruction/OldPC register enable
- `RegWrite`  out  1  register-file write enable
- `ResultSrc`  out  2  00=ALUOut, 01=Data, 10=ALUResult
- `ALUSrcA`  out  2  00=PC, 01=OldPC, 10=rs1 latch, 11=zero
- `ALUSrcB`  out  2  00=rs2 latch, 01=ImmExt, 10=constant 4
- `ImmSrc`  out  4  0=I, 1=S, 2=B, 3=J, 4=U; others reserved
- `ALUControl`  out  4  0=ADD 1=SUB 2=AND 3=OR 4=XOR 5=SLT 6=SLL 7=SRL 8=SRA 9=SLTU
- `MemMode`  out  2  00=word, 01=half, 10=byte (funct3[1:0] mapped)

## Operation
- States and transitions:
  - FETCH → DECODE.
  - DECODE → by op:
    - lw/sw → MEMADR
    - R → EXECR
    - I-ALU → EXECI
    - jal → JAL
    - jalr → JALR
    - branch → BRANCH
    - lui → LUI
    - auipc → AUIPC
    - unknown → FETCH
  - MEMADR → MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD → MEMWB.
  - EXECR, EXECI, JAL, JALR, LUI and AUIPC → ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BRANCH → FETCH.
- State outputs; anything not listed is 0:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, PCWrite=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=ADD. Computes the branch/jal target into ALUOut.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ADD.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - EXECR: ALUSrcA=10, ALUSrcB=00, funct-decoded op.
  - EXECI: ALUSrcA=10, ALUSrcB=01, funct-decoded op.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=00, PCWrite=1. PC gets the target latched in DECODE; rd gets PC+4 via ALUWB.
  - JALR: ALUSrcA=10, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=1, then stores OldPC+4 in ALUWB. The ALUOut register holds OldPC+4 computed in this cycle's second half, via a JALR2 substate if needed. JALR2 is a legal added state: ALUSrcA=01, ALUSrcB=10, ADD → ALUWB.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, SUB, ResultSrc=00. PCWrite=taken, where taken is:
    - beq: Zero
    - bne: !Zero
    - blt: Sign
    - bge: !Sign
    - any other funct3: 0
  - LUI: ALUSrcA=11, ALUSrcB=01, ADD.
  - AUIPC: ALUSrcA=01, ALUSrcB=01, ADD.
- ALU decode, active only in EXECR/EXECI:
  - funct3 000 → ADD. It is SUB only when R-type and funct7b5=1.
  - 001 → SLL, 010 → SLT, 011 → SLTU, 100 → XOR, 110 → OR, 111 → AND.
  - 101 → SRL, or SRA when funct7b5=1 (for both R and I).
- ImmSrc is decoded from op every cycle, independent of state. Unknown op gives 0.
- MemMode is decoded from funct3[1:0]: 00→byte 10, 01→half 01, 10→word 00, 11→word.

## Timing
- All outputs are a pure function of state plus the latched instr fields. Branch PCWrite also depends on Zero/Sign, combinationally within the same cycle.
- Reset value of every output is the FETCH decode: PCWrite=1, IRWrite=1, ALUSrcB=10, ResultSrc=10, all others 0.
- Asserting reset mid-instruction returns to FETCH asynchronously. The next rising edge after release performs a fetch.
- CPI:
  - lw 5
  - sw 4
  - R/I 4
  - branch 3
  - jal 4
  - jalr 5
  - lui/auipc 4
  - unknown op 2, with no register or memory write.
- MemWrite is high exactly one cycle per sw. RegWrite is high exactly one cycle per writing instruction.

## Structure
- `multicycle_pkg`: `state_t` enum, `alu_op_t` encodings, `imm_src_t`, `ResultSrc`/`ALUSrc` select constants and RV32I opcode constants.
- One sub-module, `alu_decoder` (op, funct3, funct7b5, ExecPhase → ALUControl); the FSM and the branch logic stay in the top.

## Test plan
- Reset held 3 cycles, then released → state FETCH, PCWrite=1, IRWrite=1, MemWrite=0; DECODE on the next edge.
- lw (op 0000011, funct3 010) → FETCH→DECODE→MEMADR→MEMREAD→MEMWB, RegWrite only in cycle 5, MemMode=00.
- sw byte (op 0100011, funct3 000) → MemWrite=1 only in cycle 4, AdrSrc=1, MemMode=10.
- sub (op 0110011, funct3 000, funct7b5=1) → ALUControl=0001 in EXECR. addi with funct7b5=1 → 0000. srai → 1000.
- bne with Zero=1 → PCWrite=0 in BRANCH. With Zero=0 → PCWrite=1. bge with Sign=1 → PCWrite=0.
- Illegal op 1111111 → return to FETCH after DECODE, no RegWrite/MemWrite. Reset asserted during MEMREAD → FETCH immediately, no RegWrite.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared types, select encodings and RV32I opcodes for the multicycle sequencer.
package multicycle_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWRITE = 4'd4,
      S_MEMWB    = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_JAL      = 4'd9,
      S_JALR     = 4'd10,
      S_JALR2    = 4'd11,
      S_BRANCH   = 4'd12,
      S_LUI      = 4'd13,
      S_AUIPC    = 4'd14
   } state_t;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLL  = 4'd6,
      ALU_SRL  = 4'd7,
      ALU_SRA  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_t;

   typedef enum logic [3:0] {
      IMM_I = 4'd0,
      IMM_S = 4'd1,
      IMM_B = 4'd2,
      IMM_J = 4'd3,
      IMM_U = 4'd4
   } imm_src_t;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] MEM_WORD = 2'b00;
   localparam logic [1:0] MEM_HALF = 2'b01;
   localparam logic [1:0] MEM_BYTE = 2'b10;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // Immediate format follows the opcode alone; R-type and unknown ops fall back to I.
   function automatic imm_src_t imm_src_of(input logic [6:0] op);
      case (op)
         OP_STORE:          return IMM_S;
         OP_BRANCH:         return IMM_B;
         OP_JAL:            return IMM_J;
         OP_LUI, OP_AUIPC:  return IMM_U;
         default:           return IMM_I;
      endcase
   endfunction

   function automatic logic [1:0] mem_mode_of(input logic [1:0] f3_lo);
      case (f3_lo)
         2'b00:   return MEM_BYTE;
         2'b01:   return MEM_HALF;
         default: return MEM_WORD;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU operation decode from funct fields; outside the execute phases it yields ADD.
module alu_decoder
   import multicycle_pkg::*;
(
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       ExecPhase,
   output logic [3:0] ALUControl
);

   // funct7b5 only selects SUB for register-register ops, but picks SRA for both R and I shifts.
   always_comb begin
      ALUControl = ALU_ADD;
      if (ExecPhase) begin
         case (funct3)
            3'b000:  ALUControl = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  ALUControl = ALU_SLL;
            3'b010:  ALUControl = ALU_SLT;
            3'b011:  ALUControl = ALU_SLTU;
            3'b100:  ALUControl = ALU_XOR;
            3'b101:  ALUControl = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  ALUControl = ALU_OR;
            default: ALUControl = ALU_AND;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main Moore sequencer of the multicycle core.
//  state    | meaning
//  FETCH    | read instr at PC, PC <= PC+4, latch IR/OldPC
//  DECODE   | ALUOut <= OldPC+imm (branch/jal target)
//  MEMADR   | ALUOut <= rs1+imm
//  MEMREAD  | read data at ALUOut
//  MEMWRITE | write rs2 at ALUOut
//  MEMWB    | rd <= loaded data
//  EXECR    | ALUOut <= rs1 op rs2
//  EXECI    | ALUOut <= rs1 op imm
//  ALUWB    | rd <= ALUOut
//  JAL      | PC <= target, ALUOut <= OldPC+4
//  JALR     | PC <= rs1+imm
//  JALR2    | ALUOut <= OldPC+4
//  BRANCH   | compare rs1/rs2, PC <= target when taken
//  LUI      | ALUOut <= 0+imm
//  AUIPC    | ALUOut <= OldPC+imm
module multicycle_ctrl
   import multicycle_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       Sign,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [3:0] ImmSrc,
   output logic [3:0] ALUControl,
   output logic [1:0] MemMode
);

   state_t     state_q, state_d;
   logic       exec_phase;
   logic       taken;
   logic [3:0] dec_alu;

   assign exec_phase = (state_q == S_EXECR) || (state_q == S_EXECI);
   assign ImmSrc     = imm_src_of(op);
   assign MemMode    = mem_mode_of(funct3[1:0]);

   alu_decoder u_alu_decoder (
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .ExecPhase  (exec_phase),
      .ALUControl (dec_alu)
   );

   // State register; reset lands in FETCH so the first edge after release fetches.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   // Branch condition from the SUB flags; unsupported funct3 never branches.
   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'b000:  taken = Zero;
         3'b001:  taken = ~Zero;
         3'b100:  taken = Sign;
         3'b101:  taken = ~Sign;
         default: taken = 1'b0;
      endcase
   end

   // Next-state sequencing.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_R:              state_d = S_EXECR;
               OP_I:              state_d = S_EXECI;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_LUI:            state_d = S_LUI;
               OP_AUIPC:          state_d = S_AUIPC;
               default:           state_d = S_FETCH;
            endcase
         end
         S_MEMADR:  state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD: state_d = S_MEMWB;
         S_JALR:    state_d = S_JALR2;
         S_EXECR, S_EXECI, S_JAL, S_JALR2, S_LUI, S_AUIPC: state_d = S_ALUWB;
         default:   state_d = S_FETCH;
      endcase
   end

   // Per-state datapath controls.
   always_comb begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_RS2;
      ALUControl = dec_alu;
      case (state_q)
         S_FETCH: begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMREAD:  AdrSrc = 1'b1;
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            RegWrite  = 1'b1;
         end
         S_EXECR:    ALUSrcA = SRCA_RS1;
         S_EXECI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
         end
         S_ALUWB:    RegWrite = 1'b1;
         S_JAL: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_FOUR;
            PCWrite = 1'b1;
         end
         S_JALR: begin
            ALUSrcA   = SRCA_RS1;
            ALUSrcB   = SRCB_IMM;
            ResultSrc = RES_ALURESULT;
            PCWrite   = 1'b1;
         end
         S_JALR2: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_FOUR;
         end
         S_BRANCH: begin
            ALUSrcA    = SRCA_RS1;
            ALUControl = ALU_SUB;
            PCWrite    = taken;
         end
         S_LUI: begin
            ALUSrcA = SRCA_ZERO;
            ALUSrcB = SRCB_IMM;
         end
         S_AUIPC: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: per-cycle comparison against an instruction-level model.
module tb_multicycle_ctrl;

   typedef struct packed {
      logic       pcw, adr, memw, irw, regw;
      logic [1:0] res, srca, srcb;
      logic [3:0] imm, aluc;
      logic [1:0] mm;
   } outv_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] op = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic       funct7b5 = 1'b0;
   logic       Zero = 1'b0, Sign = 1'b0;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, MemMode;
   logic [3:0] ImmSrc, ALUControl;

   int checks = 0;
   int errors = 0;
   outv_t dut_v;
   outv_t obs [8];

   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .Sign(Sign), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ImmSrc(ImmSrc), .ALUControl(ALUControl), .MemMode(MemMode)
   );

   assign dut_v = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                   ALUSrcA, ALUSrcB, ImmSrc, ALUControl, MemMode};

   always #5 clk = ~clk;

   // instruction classes: 0 lw 1 sw 2 R 3 I 4 jal 5 jalr 6 branch 7 lui 8 auipc 9 unknown
   function automatic int classify(input logic [6:0] o);
      case (o)
         7'b0000011: return 0;
         7'b0100011: return 1;
         7'b0110011: return 2;
         7'b0010011: return 3;
         7'b1101111: return 4;
         7'b1100111: return 5;
         7'b1100011: return 6;
         7'b0110111: return 7;
         7'b0010111: return 8;
         default:    return 9;
      endcase
   endfunction

   function automatic int cpi(input logic [6:0] o);
      int t [10] = '{5, 4, 4, 4, 4, 5, 3, 4, 4, 2};
      return t[classify(o)];
   endfunction

   function automatic logic [3:0] alu_ref(input int cls, input logic [2:0] f3, input logic f7);
      case (f3)
         3'd0: return (cls == 2 && f7) ? 4'd1 : 4'd0;
         3'd1: return 4'd6;
         3'd2: return 4'd5;
         3'd3: return 4'd9;
         3'd4: return 4'd4;
         3'd5: return f7 ? 4'd8 : 4'd7;
         3'd6: return 4'd3;
         default: return 4'd2;
      endcase
   endfunction

   // Expected outputs in cycle k (0 = fetch) of an instruction.
   function automatic outv_t model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                   input logic z, input logic s, input int k);
      outv_t e = '0;
      int cls = classify(o);
      logic tk;
      case (cls)
         1: e.imm = 4'd1;
         6: e.imm = 4'd2;
         4: e.imm = 4'd3;
         7, 8: e.imm = 4'd4;
         default: e.imm = 4'd0;
      endcase
      e.mm = (f3[1:0] == 2'd0) ? 2'd2 : (f3[1:0] == 2'd1) ? 2'd1 : 2'd0;
      tk = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : (f3 == 3'd4) ? s : (f3 == 3'd5) ? !s : 1'b0;
      if (k == 0) begin
         e.pcw = 1; e.irw = 1; e.srcb = 2; e.res = 2;
      end else if (k == 1) begin
         e.srca = 1; e.srcb = 1;
      end else begin
         case (cls)
            0, 1: begin
               if (k == 2) begin e.srca = 2; e.srcb = 1; end
               else if (k == 3) begin e.adr = 1; e.memw = (cls == 1); end
               else begin e.res = 1; e.regw = 1; end
            end
            2, 3: begin
               if (k == 2) begin e.srca = 2; e.srcb = (cls == 3) ? 2'd1 : 2'd0; e.aluc = alu_ref(cls, f3, f7); end
               else e.regw = 1;
            end
            4: begin
               if (k == 2) begin e.srca = 1; e.srcb = 2; e.pcw = 1; end
               else e.regw = 1;
            end
            5: begin
               if (k == 2) begin e.srca = 2; e.srcb = 1; e.res = 2; e.pcw = 1; end
               else if (k == 3) begin e.srca = 1; e.srcb = 2; end
               else e.regw = 1;
            end
            6: begin e.srca = 2; e.aluc = 4'd1; e.pcw = tk; end
            7, 8: begin
               if (k == 2) begin e.srca = (cls == 7) ? 2'd3 : 2'd1; e.srcb = 1; end
               else e.regw = 1;
            end
            default: ;
         endcase
      end
      return e;
   endfunction

   task automatic check1(input string name, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic run_cycles(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int ncyc, input logic rnd, input logic z0, input logic s0);
      outv_t e;
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk);
         op = o; funct3 = f3; funct7b5 = f7;
         Zero = rnd ? 1'($urandom_range(0, 1)) : z0;
         Sign = rnd ? 1'($urandom_range(0, 1)) : s0;
         #1;
         e = model(o, f3, f7, Zero, Sign, k);
         obs[k] = dut_v;
         checks++;
         if (dut_v !== e) begin
            errors++;
            $display("FAIL cycle k=%0d op=%b f3=%b f7=%b got=%h exp=%h", k, o, f3, f7, dut_v, e);
         end
      end
   endtask

   task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic z0, input logic s0);
      run_cycles(o, f3, f7, cpi(o), 1'b0, z0, s0);
   endtask

   initial begin
      logic [6:0] ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
                              7'b1100111, 7'b1100011, 7'b0110111, 7'b0010111};
      logic [6:0] o;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check1("rst_pcwrite", {3'b0, PCWrite}, 4'd1);
      check1("rst_irwrite", {3'b0, IRWrite}, 4'd1);
      check1("rst_memwrite", {3'b0, MemWrite}, 4'd0);
      check1("rst_alusrcb", {2'b0, ALUSrcB}, 4'd2);
      @(posedge clk); #2 reset = 1'b0;

      run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
      check1("lw_regw_c4", {3'b0, obs[3].regw}, 4'd0);
      check1("lw_regw_c5", {3'b0, obs[4].regw}, 4'd1);
      check1("lw_memmode", {2'b0, obs[4].mm}, 4'd0);

      run_instr(7'b0100011, 3'b000, 1'b0, 1'b0, 1'b0);
      check1("sw_memw_c4", {3'b0, obs[3].memw}, 4'd1);
      check1("sw_adr_c4", {3'b0, obs[3].adr}, 4'd1);
      check1("sw_memmode", {2'b0, obs[3].mm}, 4'd2);

      run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0);
      check1("sub_aluc", obs[2].aluc, 4'd1);
      run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0);
      check1("addi_aluc", obs[2].aluc, 4'd0);
      run_instr(7'b0010011, 3'b101, 1'b1, 1'b0, 1'b0);
      check1("srai_aluc", obs[2].aluc, 4'd8);

      run_instr(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0);
      check1("bne_z1_pcw", {3'b0, obs[2].pcw}, 4'd0);
      run_instr(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0);
      check1("bne_z0_pcw", {3'b0, obs[2].pcw}, 4'd1);
      run_instr(7'b1100011, 3'b101, 1'b0, 1'b0, 1'b1);
      check1("bge_s1_pcw", {3'b0, obs[2].pcw}, 4'd0);

      run_instr(7'b1111111, 3'b010, 1'b0, 1'b0, 1'b0);
      check1("illegal_regw", {3'b0, obs[1].regw}, 4'd0);
      run_instr(7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0);
      run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0);

      // reset in MEMREAD: outputs fall back to fetch decode right away
      run_cycles(7'b0000011, 3'b010, 1'b0, 4, 1'b0, 1'b0, 1'b0);
      #1 reset = 1'b1;
      #1;
      check1("midrst_regw", {3'b0, RegWrite}, 4'd0);
      check1("midrst_irwrite", {3'b0, IRWrite}, 4'd1);
      check1("midrst_adrsrc", {3'b0, AdrSrc}, 4'd0);
      @(posedge clk); #2 reset = 1'b0;
      run_instr(7'b0110111, 3'b011, 1'b0, 1'b0, 1'b0);

      for (int n = 0; n < 400; n++) begin
         int idx = $urandom_range(0, 9);
         o = (idx == 9) ? 7'($urandom_range(0, 127)) : ops[idx];
         run_cycles(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), cpi(o), 1'b1, 1'b0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
